// File: rtl/seq_divider_if.sv
// Start/Done handshake and operand/result bundle between the lab controller and seq_divider.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, dividend, divisor,
    input  busy, done, div_by_zero, quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, div_by_zero, quotient, remainder
  );
endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock, trial subtract through a ripple FA chain.
//
// state  | meaning
// S_IDLE | waiting for start; results held
// S_RUN  | one trial subtraction per edge, WIDTH iterations
// S_DONE | done pulse for one cycle; start here is accepted as in S_IDLE
module seq_divider #(
  parameter int WIDTH = 8
) (
  input logic          clk_sys,
  input logic          rst_n,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             dbz_r;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   sub_a;
  logic [WIDTH:0]   sub_b;
  logic [WIDTH-1:0] diff;
  logic [WIDTH+1:0] carry;
  logic             no_borrow;
  logic [WIDTH-1:0] p_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             last_iter;
  logic             divisor_zero;

  // Subtract by adding the inverted divisor with carry-in 1; carry-out 1 means no borrow.
  assign sub_a    = {p, q[WIDTH-1]};
  assign sub_b    = ~{1'b0, divisor_r};
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign diff[i]    = sub_a[i] ^ sub_b[i] ^ carry[i];
    assign carry[i+1] = (sub_a[i] & sub_b[i]) | (carry[i] & (sub_a[i] ^ sub_b[i]));
  end

  // The kept partial remainder is always below the divisor, so the top difference bit is
  // never needed; only the final carry of that stage decides the quotient bit.
  assign carry[WIDTH+1] = (sub_a[WIDTH] & sub_b[WIDTH]) | (carry[WIDTH] & (sub_a[WIDTH] ^ sub_b[WIDTH]));
  assign no_borrow      = carry[WIDTH+1];

  assign p_nxt        = no_borrow ? diff : sub_a[WIDTH-1:0];
  assign q_nxt        = {q[WIDTH-2:0], no_borrow};
  assign last_iter    = (count == CW'(WIDTH - 1));
  assign divisor_zero = (bus.divisor == '0);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = divisor_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_iter) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          state_nxt = divisor_zero ? S_DONE : S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      p           <= '0;
      q           <= '0;
      divisor_r   <= '0;
      count       <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            divisor_r <= bus.divisor;
            dbz_r     <= 1'b0;
            if (divisor_zero) begin
              quotient_r  <= '1;
              remainder_r <= bus.dividend;
              dbz_r       <= 1'b1;
            end else begin
              p     <= '0;
              q     <= bus.dividend;
              count <= '0;
            end
          end
        end
        S_RUN: begin
          p     <= p_nxt;
          q     <= q_nxt;
          count <= count + 1'b1;
          if (last_iter) begin
            quotient_r  <= q_nxt;
            remainder_r <= p_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state == S_RUN);
  assign bus.done        = (state == S_DONE);
  assign bus.div_by_zero = dbz_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: vector table plus hand-written corner sequences, results via scoreboard.
module tb_seq_divider;
  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } exp_t;

  typedef struct {
    logic [7:0] dd;
    logic [7:0] dv;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         lat;
    int         nbusy;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   done_cnt;
  exp_t sb[$];
  vec_t vecs[6];

  seq_divider_if #(.WIDTH(8)) bus ();

  seq_divider #(.WIDTH(8)) dut (
    .clk_sys (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (bus.done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("sb_quotient", int'(bus.quotient), int'(e.q));
        check("sb_remainder", int'(bus.remainder), int'(e.r));
        check("sb_div_by_zero", int'(bus.div_by_zero), int'(e.dbz));
      end
    end
  end

  task automatic run_op(input logic [7:0] dd, input logic [7:0] dv, input logic [7:0] eq,
                        input logic [7:0] er, input logic edbz, input int elat, input int ebusy);
    int lat;
    int nbusy;
    bus.dividend = dd;
    bus.divisor  = dv;
    bus.start    = 1'b1;
    sb.push_back('{eq, er, edbz});
    tick();
    bus.start = 1'b0;
    lat   = 1;
    nbusy = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) nbusy++;
      tick();
      lat++;
    end
    check("latency", lat, elat);
    check("busy_cycles", nbusy, ebusy);
    tick();
    check("done_one_cycle", int'(bus.done), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int d0;
    int n;
    int first;
    int second;
    logic [7:0] dd;
    logic [7:0] dv;

    n_cmp    = 0;
    n_err    = 0;
    done_cnt = 0;
    vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 9, 8};
    vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 9, 8};
    vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0, 9, 8};
    vecs[3] = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 9, 8};
    vecs[4] = '{8'd77,  8'd0,   8'd255, 8'd77, 1'b1, 1, 0};
    vecs[5] = '{8'd10,  8'd3,   8'd3,   8'd1,  1'b0, 9, 8};

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #23;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_quotient", int'(bus.quotient), 0);
    check("rst_remainder", int'(bus.remainder), 0);
    check("rst_div_by_zero", int'(bus.div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].dd, vecs[i].dv, vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].lat, vecs[i].nbusy);
      check("hold_quotient", int'(bus.quotient), int'(vecs[i].q));
      check("hold_remainder", int'(bus.remainder), int'(vecs[i].r));
      check("hold_div_by_zero", int'(bus.div_by_zero), int'(vecs[i].dbz));
    end

    // Start re-pulsed mid-run must be ignored.
    d0 = done_cnt;
    bus.dividend = 8'd100;
    bus.divisor  = 8'd7;
    bus.start    = 1'b1;
    sb.push_back('{8'd14, 8'd2, 1'b0});
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.dividend = 8'd50;
    bus.divisor  = 8'd5;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 20) begin
      tick();
      n++;
    end
    check("ignore_done_seen", int'(bus.done), 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("ignore_hold_q", int'(bus.quotient), 14);
      check("ignore_hold_r", int'(bus.remainder), 2);
    end
    check("ignore_done_count", done_cnt - d0, 1);

    // Asynchronous reset in RUN cycle 4.
    bus.dividend = 8'd100;
    bus.divisor  = 8'd7;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_quotient", int'(bus.quotient), 0);
    check("midrst_remainder", int'(bus.remainder), 0);
    check("midrst_div_by_zero", int'(bus.div_by_zero), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_done", int'(bus.done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("postrst_idle", int'(bus.busy), 0);
    run_op(8'd200, 8'd6, 8'd33, 8'd2, 1'b0, 9, 8);

    // Start held high: second operation accepted in DONE.
    first  = -1;
    second = -1;
    bus.dividend = 8'd200;
    bus.divisor  = 8'd6;
    bus.start    = 1'b1;
    sb.push_back('{8'd33, 8'd2, 1'b0});
    sb.push_back('{8'd2, 8'd1, 1'b0});
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (i == 1) begin
        bus.dividend = 8'd9;
        bus.divisor  = 8'd4;
      end
      if (i == 10) bus.start = 1'b0;
      if (bus.done) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    check("b2b_first_done", first, 9);
    check("b2b_second_done", second, 18);

    for (int i = 0; i < 1000; i++) begin
      dd = 8'($urandom_range(0, 255));
      dv = 8'($urandom_range(0, 255));
      if (dv == 8'd0) begin
        run_op(dd, dv, 8'hFF, dd, 1'b1, 1, 0);
      end else begin
        run_op(dd, dv, 8'(int'(dd) / int'(dv)), 8'(int'(dd) % int'(dv)), 1'b0, 9, 8);
        check("rand_identity", int'(bus.quotient) * int'(dv) + int'(bus.remainder), int'(dd));
        check("rand_rem_below_div", int'(bus.remainder < dv), 1);
      end
    end

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
